// File: rtl/five_row_checker_if.sv
// Request/result bundle between the move-placement logic and the five-in-a-row checker.
// master = requester (drives board and move), slave = checker.
interface five_row_checker_if;
    logic [511:0] board;
    logic         start;
    logic [3:0]   move_x;
    logic [3:0]   move_y;
    logic [1:0]   player;
    logic         busy;
    logic         done;
    logic         win;
    logic         invalid;
    logic [1:0]   win_dir;
    logic [3:0]   run_len;
    logic [3:0]   run_x;
    logic [3:0]   run_y;

    modport master (
        output board, start, move_x, move_y, player,
        input  busy, done, win, invalid, win_dir, run_len, run_x, run_y
    );

    modport slave (
        input  board, start, move_x, move_y, player,
        output busy, done, win, invalid, win_dir, run_len, run_x, run_y
    );
endinterface

// File: rtl/five_row_checker.sv
// Decides whether the stone just placed completed five-or-more in a row, walking
// each of the four line directions one cell per clock and stopping at the first win.
module five_row_checker #(
    parameter int BOARD_N = 16,
    parameter int CELL_W  = 2,
    parameter int WIN_LEN = 5
) (
    input  logic              Clck,
    input  logic              Reset,
    five_row_checker_if.slave bus
);
    localparam logic [3:0] WIN_LEN_C = 4'(WIN_LEN);

    typedef enum logic [2:0] {IDLE, CENTER, POS, NEG, EVAL, FIN} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  mx_reg, my_reg;
    logic [1:0]  player_reg;
    logic [1:0]  dir_reg;
    logic [3:0]  count_reg;
    logic [2:0]  k_reg;
    logic [2:0]  m_reg;
    logic        win_reg, invalid_reg;
    logic [1:0]  win_dir_reg;
    logic [3:0]  run_len_reg, run_x_reg, run_y_reg;
    logic        busy_next, done_next;

    logic [CELL_W-1:0] cells [BOARD_N*BOARD_N];

    generate
        for (genvar gi = 0; gi < BOARD_N*BOARD_N; gi++) begin : g_cell
            assign cells[gi] = bus.board[gi*CELL_W +: CELL_W];
        end
    endgenerate

    // One shared probe: CENTER looks at offset 0, POS at +k, NEG at -k,
    // and EVAL reuses it at -m to produce the run's start coordinate.
    logic signed [5:0] off, px, py;
    logic              in_range, probe_match, center_ok, is_win;

    always_comb begin
        off = '0;
        case (state_reg)
            POS:     off = $signed({3'b000, k_reg});
            NEG:     off = -$signed({3'b000, k_reg});
            EVAL:    off = -$signed({3'b000, m_reg});
            default: off = '0;
        endcase
        px = $signed({2'b00, mx_reg}) + ((dir_reg == 2'd1) ? 6'sd0 : off);
        py = $signed({2'b00, my_reg});
        case (dir_reg)
            2'd0:    py = $signed({2'b00, my_reg});
            2'd3:    py = $signed({2'b00, my_reg}) - off;
            default: py = $signed({2'b00, my_reg}) + off;
        endcase
    end

    // Any coordinate outside 0..15 (including wrapped overflow) has a nonzero top pair.
    assign in_range    = (px[5:4] == 2'b00) && (py[5:4] == 2'b00);
    assign probe_match = in_range && (cells[{py[3:0], px[3:0]}] == player_reg);
    assign center_ok   = ((player_reg == 2'b01) || (player_reg == 2'b10)) && probe_match;
    assign is_win      = (count_reg >= WIN_LEN_C);

    always_ff @(posedge Clck or posedge Reset) begin
        if (Reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = CENTER;
            CENTER:  state_next = center_ok ? POS : FIN;
            POS:     if (!probe_match || k_reg == 3'd4) state_next = NEG;
            NEG:     if (!probe_match || k_reg == 3'd4) state_next = EVAL;
            EVAL:    state_next = (is_win || dir_reg == 2'd3) ? FIN : POS;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_next = 1'b0;
        done_next = 1'b0;
        case (state_reg)
            CENTER, POS, NEG, EVAL: busy_next = 1'b1;
            FIN:                    done_next = 1'b1;
            default:                ;
        endcase
    end

    always_ff @(posedge Clck or posedge Reset) begin
        if (Reset) begin
            mx_reg      <= '0;
            my_reg      <= '0;
            player_reg  <= '0;
            dir_reg     <= '0;
            count_reg   <= '0;
            k_reg       <= '0;
            m_reg       <= '0;
            win_reg     <= 1'b0;
            invalid_reg <= 1'b0;
            win_dir_reg <= '0;
            run_len_reg <= '0;
            run_x_reg   <= '0;
            run_y_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: if (bus.start) begin
                    mx_reg      <= bus.move_x;
                    my_reg      <= bus.move_y;
                    player_reg  <= bus.player;
                    dir_reg     <= '0;
                    win_reg     <= 1'b0;
                    invalid_reg <= 1'b0;
                    win_dir_reg <= '0;
                    run_len_reg <= '0;
                    run_x_reg   <= '0;
                    run_y_reg   <= '0;
                end
                CENTER: begin
                    if (!center_ok) begin
                        invalid_reg <= 1'b1;
                        win_reg     <= 1'b0;
                    end
                    count_reg <= 4'd1;
                    k_reg     <= 3'd1;
                    m_reg     <= 3'd0;
                end
                POS: begin
                    if (probe_match) count_reg <= count_reg + 4'd1;
                    k_reg <= (probe_match && k_reg != 3'd4) ? k_reg + 3'd1 : 3'd1;
                end
                NEG: begin
                    if (probe_match) begin
                        count_reg <= count_reg + 4'd1;
                        m_reg     <= k_reg;
                    end
                    k_reg <= k_reg + 3'd1;
                end
                EVAL: begin
                    if (is_win || count_reg > run_len_reg) begin
                        win_dir_reg <= dir_reg;
                        run_len_reg <= count_reg;
                        run_x_reg   <= px[3:0];
                        run_y_reg   <= py[3:0];
                    end
                    if (is_win) begin
                        win_reg <= 1'b1;
                    end else if (dir_reg != 2'd3) begin
                        dir_reg   <= dir_reg + 2'd1;
                        count_reg <= 4'd1;
                        k_reg     <= 3'd1;
                        m_reg     <= 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = busy_next;
    assign bus.done    = done_next;
    assign bus.win     = win_reg;
    assign bus.invalid = invalid_reg;
    assign bus.win_dir = win_dir_reg;
    assign bus.run_len = run_len_reg;
    assign bus.run_x   = run_x_reg;
    assign bus.run_y   = run_y_reg;
endmodule

// File: tb/tb_five_row_checker.sv
// Self-checking bench for five_row_checker: directed corner cases plus random boards
// compared against a line-counting reference model.
module tb_five_row_checker;
    logic Clck  = 1'b0;
    logic Reset = 1'b1;

    five_row_checker_if bus();

    five_row_checker dut (
        .Clck  (Clck),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clck = ~Clck;

    int n_vec = 0;
    int n_err = 0;
    int brd [16][16];

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_board();
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                brd[x][y] = 0;
    endtask

    task automatic load_board();
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                bus.board[x*2 + y*32 +: 2] = 2'(brd[x][y]);
    endtask

    function automatic int cell_at(input int x, input int y);
        if (x < 0 || x > 15 || y < 0 || y > 15) return -1;
        return brd[x][y];
    endfunction

    // Reference: count matching stones in each direction (up to 4 each way).
    task automatic model(input int mx, input int my, input int pl,
                         output int e_win, output int e_inv, output int e_dir,
                         output int e_len, output int e_rx, output int e_ry);
        int dxs [4];
        int dys [4];
        int f, b, n;
        dxs = '{1, 0, 1, 1};
        dys = '{0, 1, 1, -1};
        e_win = 0; e_inv = 0; e_dir = 0; e_len = 0; e_rx = 0; e_ry = 0;
        if ((pl != 1 && pl != 2) || brd[mx][my] != pl) begin
            e_inv = 1;
            return;
        end
        for (int d = 0; d < 4; d++) begin
            f = 0;
            while (f < 4 && cell_at(mx + (f+1)*dxs[d], my + (f+1)*dys[d]) == pl) f++;
            b = 0;
            while (b < 4 && cell_at(mx - (b+1)*dxs[d], my - (b+1)*dys[d]) == pl) b++;
            n = 1 + f + b;
            if (n >= 5 || n > e_len) begin
                e_len = n;
                e_dir = d;
                e_rx  = mx - b*dxs[d];
                e_ry  = my - b*dys[d];
            end
            if (n >= 5) begin
                e_win = 1;
                return;
            end
        end
    endtask

    // Issue one request, wait for done, compare against the model; returns latency.
    task automatic run_check(input string tag, input int mx, input int my, input int pl,
                             output int lat);
        int e_win, e_inv, e_dir, e_len, e_rx, e_ry;
        model(mx, my, pl, e_win, e_inv, e_dir, e_len, e_rx, e_ry);
        load_board();
        bus.move_x = 4'(mx);
        bus.move_y = 4'(my);
        bus.player = 2'(pl);
        bus.start  = 1'b1;
        @(posedge Clck);
        #1 bus.start = 1'b0;
        check({tag, "_busy"}, int'(bus.busy), 1);
        lat = 0;
        while (!bus.done && lat < 45) begin
            @(posedge Clck);
            #1 lat++;
        end
        check({tag, "_lat_bound"}, int'(lat <= 38), 1);
        check({tag, "_win"}, int'(bus.win), e_win);
        check({tag, "_invalid"}, int'(bus.invalid), e_inv);
        check({tag, "_run_len"}, int'(bus.run_len), e_len);
        check({tag, "_run_x"}, int'(bus.run_x), e_rx);
        check({tag, "_run_y"}, int'(bus.run_y), e_ry);
        if (!e_inv) check({tag, "_win_dir"}, int'(bus.win_dir), e_dir);
        $display("txn %s move=(%0d,%0d) p=%0d win=%0d inv=%0d dir=%0d len=%0d run=(%0d,%0d) lat=%0d",
                 tag, mx, my, pl, bus.win, bus.invalid, bus.win_dir, bus.run_len,
                 bus.run_x, bus.run_y, lat);
        @(posedge Clck);
        #1;
        check({tag, "_done_pulse"}, int'(bus.done), 0);
        check({tag, "_idle_busy"}, int'(bus.busy), 0);
        check({tag, "_hold_win"}, int'(bus.win), e_win);
    endtask

    int lat, ndone;
    int lx [8];
    int ly [8];
    int nl, pl, d, len, sx, sy, mx, my, r;

    initial begin
        bus.board  = '0;
        bus.start  = 1'b0;
        bus.move_x = '0;
        bus.move_y = '0;
        bus.player = '0;
        #12;
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_win", int'(bus.win), 0);
        check("reset_run_len", int'(bus.run_len), 0);
        Reset = 1'b0;
        @(posedge Clck);
        #1;

        // Horizontal win
        clear_board();
        for (int x = 3; x <= 7; x++) brd[x][8] = 1;
        run_check("horiz", 5, 8, 1, lat);
        check("horiz_win_c", int'(bus.win), 1);
        check("horiz_dir_c", int'(bus.win_dir), 0);
        check("horiz_len_c", int'(bus.run_len), 5);
        check("horiz_rx_c", int'(bus.run_x), 3);
        check("horiz_ry_c", int'(bus.run_y), 8);

        // Reset mid-scan, then a normal request
        load_board();
        bus.move_x = 4'd5; bus.move_y = 4'd8; bus.player = 2'd1; bus.start = 1'b1;
        @(posedge Clck);
        #1 bus.start = 1'b0;
        repeat (4) @(posedge Clck);
        #1 check("midscan_busy", int'(bus.busy), 1);
        #2 Reset = 1'b1;
        #1;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_win", int'(bus.win), 0);
        check("abort_inv", int'(bus.invalid), 0);
        check("abort_run_len", int'(bus.run_len), 0);
        check("abort_run_x", int'(bus.run_x), 0);
        ndone = 0;
        repeat (3) begin
            @(posedge Clck);
            #1 if (bus.done) ndone++;
        end
        Reset = 1'b0;
        repeat (3) begin
            @(posedge Clck);
            #1 if (bus.done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        run_check("after_reset", 5, 8, 1, lat);

        // Anti-diagonal win touching the board edge
        clear_board();
        for (int i = 0; i < 5; i++) brd[i][15-i] = 1;
        run_check("antidiag", 0, 15, 1, lat);
        check("antidiag_win_c", int'(bus.win), 1);
        check("antidiag_dir_c", int'(bus.win_dir), 3);
        check("antidiag_rx_c", int'(bus.run_x), 0);
        check("antidiag_ry_c", int'(bus.run_y), 15);

        // Four in a row is not a win
        clear_board();
        for (int x = 10; x <= 13; x++) brd[x][2] = 2;
        run_check("nowin", 13, 2, 2, lat);
        check("nowin_win_c", int'(bus.win), 0);
        check("nowin_len_c", int'(bus.run_len), 4);
        check("nowin_dir_c", int'(bus.win_dir), 0);
        check("nowin_rx_c", int'(bus.run_x), 10);

        // Invalid: empty center
        clear_board();
        run_check("invalid", 0, 0, 1, lat);
        check("invalid_lat", lat, 1);
        check("invalid_c", int'(bus.invalid), 1);

        // Second start during a scan is ignored
        clear_board();
        for (int x = 3; x <= 7; x++) brd[x][8] = 1;
        load_board();
        bus.move_x = 4'd5; bus.move_y = 4'd8; bus.player = 2'd1; bus.start = 1'b1;
        @(posedge Clck);
        #1 bus.start = 1'b0;
        repeat (2) @(posedge Clck);
        #1;
        bus.move_x = 4'd0; bus.move_y = 4'd0; bus.player = 2'd2; bus.start = 1'b1;
        @(posedge Clck);
        #1 bus.start = 1'b0;
        ndone = 0;
        repeat (50) begin
            @(posedge Clck);
            #1 if (bus.done) ndone++;
        end
        check("busy_start_ndone", ndone, 1);
        check("busy_start_win", int'(bus.win), 1);
        check("busy_start_rx", int'(bus.run_x), 3);
        $display("txn busy_start done_pulses=%0d win=%0d run=(%0d,%0d)", ndone, bus.win, bus.run_x, bus.run_y);

        // Random boards with planted lines
        for (int t = 0; t < 80; t++) begin
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++) begin
                    r = $urandom_range(0, 9);
                    brd[x][y] = (r < 4) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
                end
            nl = 0;
            pl = $urandom_range(1, 2);
            if ($urandom_range(0, 9) < 7) begin
                d   = $urandom_range(0, 3);
                len = $urandom_range(3, 8);
                sx  = $urandom_range(0, 15);
                sy  = $urandom_range(0, 15);
                for (int i = 0; i < len; i++) begin
                    mx = sx + i * ((d == 1) ? 0 : 1);
                    my = sy + i * ((d == 0) ? 0 : (d == 3) ? -1 : 1);
                    if (mx >= 0 && mx <= 15 && my >= 0 && my <= 15) begin
                        brd[mx][my] = pl;
                        lx[nl] = mx;
                        ly[nl] = my;
                        nl++;
                    end
                end
            end
            if (nl > 0 && $urandom_range(0, 9) < 8) begin
                r  = $urandom_range(0, nl - 1);
                mx = lx[r];
                my = ly[r];
            end else begin
                mx = $urandom_range(0, 15);
                my = $urandom_range(0, 15);
            end
            pl = ($urandom_range(0, 19) < 17) ? brd[mx][my] : int'($urandom_range(0, 3));
            run_check($sformatf("rnd%0d", t), mx, my, pl, lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
